fetch_stage: RTL and testbench

//   Instruction-fetch stage of the 8-bit pipelined CPU; upstream of decode, branch and bubble control.

---
 rtl/cpu_pkg.sv | 23 ++
 rtl/fetch_stage_if_id_reg.sv | 43 ++++
 rtl/fetch_stage.sv | 117 +++++++++++
 tb/tb_fetch_stage.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared encodings for the 8-bit pipelined CPU
package cpu_pkg;

    localparam logic [1:0] PCSEL_SEQ = 2'b00;
    localparam logic [1:0] PCSEL_BR  = 2'b01;
    localparam logic [1:0] PCSEL_RET = 2'b10;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_CALL = 4'hb;
    localparam logic [3:0] OP_RET  = 4'hd;

    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_SQUASH = 2'd2
    } fetch_state_e;

    // True for the pc_sel codes that move the PC away from the sequential path.
    function automatic logic is_redirect(input logic [1:0] sel);
        return (sel == PCSEL_BR) || (sel == PCSEL_RET);
    endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// rtl/fetch_stage_if_id_reg.sv - IF/ID pipeline register with hold and squash-to-NOP
module if_id_reg #(
    parameter int               AW      = 8,
    parameter int               IW      = 8,
    parameter logic [IW-1:0]    NOP_INS = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          hold_i,
    input  logic          squash_i,
    input  logic [IW-1:0] ins_i,
    input  logic [AW-1:0] pc_next_i,
    output logic [IW-1:0] ins_o,
    output logic [AW-1:0] pc_next_o,
    output logic          valid_o
);

    logic [IW-1:0] ins_q;
    logic [AW-1:0] pc_next_q;
    logic          valid_q;

    // Squash wins over hold so a redirect during a stall still kills the slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ins_q     <= NOP_INS;
            pc_next_q <= '0;
            valid_q   <= 1'b0;
        end else if (squash_i) begin
            ins_q     <= NOP_INS;
            pc_next_q <= '0;
            valid_q   <= 1'b0;
        end else if (!hold_i) begin
            ins_q     <= ins_i;
            pc_next_q <= pc_next_i;
            valid_q   <= 1'b1;
        end
    end

    assign ins_o     = ins_q;
    assign pc_next_o = pc_next_q;
    assign valid_o   = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch: PC, link register, next-PC select, IF/ID
module fetch_stage
    import cpu_pkg::*;
#(
    parameter int            AW          = 8,
    parameter int            IW          = 8,
    parameter logic [AW-1:0] RESET_PC    = 8'h00,
    parameter logic [IW-1:0] NOP_INS     = 8'h00,
    parameter int            FLUSH_DEPTH = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          pc_en,
    input  logic [1:0]    pc_sel,
    input  logic          lr_we,
    input  logic [AW-1:0] br_target,
    output logic [AW-1:0] imem_addr,
    input  logic [IW-1:0] imem_data,
    output logic [AW-1:0] pc,
    output logic [AW-1:0] lr,
    output logic [IW-1:0] id_ins,
    output logic [AW-1:0] id_pc_next,
    output logic          id_valid,
    output logic [15:0]   fetch_cnt
);

    localparam logic [1:0] SQ_INIT    = 2'(FLUSH_DEPTH - 1);
    localparam bit         MULTI_SLOT = (FLUSH_DEPTH > 1);

    fetch_state_e  state_q;
    logic [1:0]    squash_cnt_q;
    logic [AW-1:0] pc_q, pc_d, pc_seq;
    logic [AW-1:0] lr_q;
    logic [15:0]   fetch_cnt_q;
    logic          redirect, squash, load, hold;

    assign pc_seq = pc_q + AW'(1);

    // Decide what happens to the PC and the IF/ID slot this cycle.
    always_comb begin
        redirect = (state_q != ST_BOOT) && is_redirect(pc_sel);
        squash   = 1'b0;
        load     = 1'b0;
        pc_d     = pc_q;
        if (state_q == ST_BOOT) begin
            squash = 1'b1;
        end else if (redirect) begin
            squash = 1'b1;
            pc_d   = (pc_sel == PCSEL_RET) ? lr_q : br_target;
        end else if (pc_en) begin
            pc_d = pc_seq;
            if (state_q == ST_RUN) begin
                load = 1'b1;
            end else begin
                squash = 1'b1;
            end
        end
    end

    assign hold = !squash && !load;

    // Fetch FSM together with PC, link register and valid-fetch counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_BOOT;
            squash_cnt_q <= 2'd0;
            pc_q         <= RESET_PC;
            lr_q         <= '0;
            fetch_cnt_q  <= 16'd0;
        end else begin
            pc_q <= pc_d;
            if (lr_we && id_valid) begin
                lr_q <= id_pc_next;
            end
            if (load && (fetch_cnt_q != 16'hFFFF)) begin
                fetch_cnt_q <= fetch_cnt_q + 16'd1;
            end
            case (state_q)
                ST_BOOT: state_q <= ST_RUN;
                ST_RUN, ST_SQUASH: begin
                    if (redirect) begin
                        squash_cnt_q <= SQ_INIT;
                        state_q      <= MULTI_SLOT ? ST_SQUASH : ST_RUN;
                    end else if (pc_en && (state_q == ST_SQUASH)) begin
                        squash_cnt_q <= squash_cnt_q - 2'd1;
                        if (squash_cnt_q <= 2'd1) begin
                            state_q <= ST_RUN;
                        end
                    end
                end
                default: state_q <= ST_BOOT;
            endcase
        end
    end

    if_id_reg #(
        .AW      (AW),
        .IW      (IW),
        .NOP_INS (NOP_INS)
    ) u_if_id (
        .clk       (clk),
        .rst_n     (rst_n),
        .hold_i    (hold),
        .squash_i  (squash),
        .ins_i     (imem_data),
        .pc_next_i (pc_seq),
        .ins_o     (id_ins),
        .pc_next_o (id_pc_next),
        .valid_o   (id_valid)
    );

    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign lr        = lr_q;
    assign fetch_cnt = fetch_cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed vector bench for fetch_stage
module tb_fetch_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // depth-1 instance
    logic        rst_n, pc_en, lr_we, id_valid;
    logic [1:0]  pc_sel;
    logic [7:0]  br_target, imem_addr, imem_data, pc, lr, id_ins, id_pc_next;
    logic [15:0] fetch_cnt;
    // depth-3 instance
    logic        rst3_n, pc_en3, lr_we3, id_valid3;
    logic [1:0]  pc_sel3;
    logic [7:0]  br_target3, imem_addr3, imem_data3, pc3, lr3, id_ins3, id_pc_next3;
    logic [15:0] fetch_cnt3;

    assign imem_data  = imem_addr + 8'h10;
    assign imem_data3 = imem_addr3 + 8'h10;

    fetch_stage #(.AW(8), .IW(8), .RESET_PC(8'h00), .NOP_INS(8'h00), .FLUSH_DEPTH(1)) dut (
        .clk(clk), .rst_n(rst_n), .pc_en(pc_en), .pc_sel(pc_sel), .lr_we(lr_we),
        .br_target(br_target), .imem_addr(imem_addr), .imem_data(imem_data), .pc(pc),
        .lr(lr), .id_ins(id_ins), .id_pc_next(id_pc_next), .id_valid(id_valid),
        .fetch_cnt(fetch_cnt)
    );

    fetch_stage #(.AW(8), .IW(8), .RESET_PC(8'h00), .NOP_INS(8'h00), .FLUSH_DEPTH(3)) dut3 (
        .clk(clk), .rst_n(rst3_n), .pc_en(pc_en3), .pc_sel(pc_sel3), .lr_we(lr_we3),
        .br_target(br_target3), .imem_addr(imem_addr3), .imem_data(imem_data3), .pc(pc3),
        .lr(lr3), .id_ins(id_ins3), .id_pc_next(id_pc_next3), .id_valid(id_valid3),
        .fetch_cnt(fetch_cnt3)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        en;
        logic [1:0]  sel;
        logic [7:0]  br;
        logic        lrwe;
        logic [7:0]  pc;
        logic [7:0]  ins;
        logic [7:0]  pcn;
        logic        v;
        logic [7:0]  lr;
        logic [15:0] cnt;
    } vec_t;

    vec_t tbl[27];

    function automatic vec_t mk(logic en, logic [1:0] sel, logic [7:0] br, logic lrwe,
                                logic [7:0] epc, logic [7:0] ins, logic [7:0] pcn,
                                logic v, logic [7:0] elr, logic [15:0] cnt);
        vec_t r;
        r.en = en; r.sel = sel; r.br = br; r.lrwe = lrwe; r.pc = epc; r.ins = ins;
        r.pcn = pcn; r.v = v; r.lr = elr; r.cnt = cnt;
        return r;
    endfunction

    task automatic chk3(input string tag, input logic [7:0] epc, input logic [7:0] ins,
                        input logic [7:0] pcn, input logic v, input logic [15:0] cnt);
        check({tag, " pc3"}, 16'(pc3), 16'(epc));
        check({tag, " ins3"}, 16'(id_ins3), 16'(ins));
        check({tag, " valid3"}, 16'(id_valid3), 16'(v));
        if (v) check({tag, " pcn3"}, 16'(id_pc_next3), 16'(pcn));
        check({tag, " cnt3"}, fetch_cnt3, cnt);
    endtask

    task automatic drive3(input logic [1:0] sel, input logic [7:0] br);
        pc_sel3 = sel; br_target3 = br;
    endtask

    initial begin
        // sequential start, stall at 05, branch, CALL/RET, wrap, redirect under stall, reserved sel
        tbl[0]  = mk(1, 2'd0, 8'h00, 0, 8'h00, 8'h00, 8'h00, 0, 8'h00, 16'd0);
        tbl[1]  = mk(1, 2'd0, 8'h00, 0, 8'h01, 8'h10, 8'h01, 1, 8'h00, 16'd1);
        tbl[2]  = mk(1, 2'd0, 8'h00, 0, 8'h02, 8'h11, 8'h02, 1, 8'h00, 16'd2);
        tbl[3]  = mk(1, 2'd0, 8'h00, 0, 8'h03, 8'h12, 8'h03, 1, 8'h00, 16'd3);
        tbl[4]  = mk(1, 2'd0, 8'h00, 0, 8'h04, 8'h13, 8'h04, 1, 8'h00, 16'd4);
        tbl[5]  = mk(1, 2'd0, 8'h00, 0, 8'h05, 8'h14, 8'h05, 1, 8'h00, 16'd5);
        tbl[6]  = mk(0, 2'd0, 8'h00, 0, 8'h05, 8'h14, 8'h05, 1, 8'h00, 16'd5);
        tbl[7]  = mk(0, 2'd0, 8'h00, 0, 8'h05, 8'h14, 8'h05, 1, 8'h00, 16'd5);
        tbl[8]  = mk(1, 2'd0, 8'h00, 0, 8'h06, 8'h15, 8'h06, 1, 8'h00, 16'd6);
        tbl[9]  = mk(1, 2'd1, 8'h40, 0, 8'h40, 8'h00, 8'h00, 0, 8'h00, 16'd6);
        tbl[10] = mk(1, 2'd0, 8'h00, 0, 8'h41, 8'h50, 8'h41, 1, 8'h00, 16'd7);
        tbl[11] = mk(1, 2'd1, 8'h20, 0, 8'h20, 8'h00, 8'h00, 0, 8'h00, 16'd7);
        tbl[12] = mk(1, 2'd0, 8'h00, 0, 8'h21, 8'h30, 8'h21, 1, 8'h00, 16'd8);
        tbl[13] = mk(1, 2'd0, 8'h00, 1, 8'h22, 8'h31, 8'h22, 1, 8'h21, 16'd9);
        tbl[14] = mk(1, 2'd0, 8'h00, 0, 8'h23, 8'h32, 8'h23, 1, 8'h21, 16'd10);
        tbl[15] = mk(1, 2'd2, 8'h00, 0, 8'h21, 8'h00, 8'h00, 0, 8'h21, 16'd10);
        tbl[16] = mk(1, 2'd1, 8'h2F, 0, 8'h2F, 8'h00, 8'h00, 0, 8'h21, 16'd10);
        tbl[17] = mk(1, 2'd0, 8'h00, 0, 8'h30, 8'h3F, 8'h30, 1, 8'h21, 16'd11);
        tbl[18] = mk(1, 2'd2, 8'h00, 1, 8'h21, 8'h00, 8'h00, 0, 8'h30, 16'd11);
        tbl[19] = mk(1, 2'd0, 8'h00, 1, 8'h22, 8'h31, 8'h22, 1, 8'h30, 16'd12);
        tbl[20] = mk(1, 2'd1, 8'hFE, 0, 8'hFE, 8'h00, 8'h00, 0, 8'h30, 16'd12);
        tbl[21] = mk(1, 2'd0, 8'h00, 0, 8'hFF, 8'h0E, 8'hFF, 1, 8'h30, 16'd13);
        tbl[22] = mk(1, 2'd0, 8'h00, 0, 8'h00, 8'h0F, 8'h00, 1, 8'h30, 16'd14);
        tbl[23] = mk(1, 2'd0, 8'h00, 0, 8'h01, 8'h10, 8'h01, 1, 8'h30, 16'd15);
        tbl[24] = mk(0, 2'd1, 8'h80, 0, 8'h80, 8'h00, 8'h00, 0, 8'h30, 16'd15);
        tbl[25] = mk(1, 2'd0, 8'h00, 0, 8'h81, 8'h90, 8'h81, 1, 8'h30, 16'd16);
        tbl[26] = mk(1, 2'd3, 8'h00, 0, 8'h82, 8'h91, 8'h82, 1, 8'h30, 16'd17);

        rst_n = 1'b0; rst3_n = 1'b0;
        pc_en = 1'b1; pc_sel = 2'd0; lr_we = 1'b0; br_target = 8'h00;
        pc_en3 = 1'b1; pc_sel3 = 2'd0; lr_we3 = 1'b0; br_target3 = 8'h00;
        #12;
        check("reset pc", 16'(pc), 16'h00);
        check("reset lr", 16'(lr), 16'h00);
        check("reset ins", 16'(id_ins), 16'h00);
        check("reset pcn", 16'(id_pc_next), 16'h00);
        check("reset valid", 16'(id_valid), 16'h0);
        check("reset cnt", fetch_cnt, 16'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 27; i++) begin
            pc_en = tbl[i].en; pc_sel = tbl[i].sel; br_target = tbl[i].br; lr_we = tbl[i].lrwe;
            step();
            check($sformatf("row%0d pc", i), 16'(pc), 16'(tbl[i].pc));
            check($sformatf("row%0d ins", i), 16'(id_ins), 16'(tbl[i].ins));
            check($sformatf("row%0d valid", i), 16'(id_valid), 16'(tbl[i].v));
            if (tbl[i].v) check($sformatf("row%0d pcn", i), 16'(id_pc_next), 16'(tbl[i].pcn));
            check($sformatf("row%0d lr", i), 16'(lr), 16'(tbl[i].lr));
            check($sformatf("row%0d cnt", i), fetch_cnt, tbl[i].cnt);
        end
        pc_en = 1'b1; pc_sel = 2'd0; lr_we = 1'b0; br_target = 8'h00;

        // FLUSH_DEPTH=3: three squashed slots, redirect restarts count
        rst3_n = 1'b1;
        drive3(2'd0, 8'h00); step(); chk3("s1", 8'h00, 8'h00, 8'h00, 0, 16'd0);
        drive3(2'd0, 8'h00); step(); chk3("s2", 8'h01, 8'h10, 8'h01, 1, 16'd1);
        drive3(2'd1, 8'h40); step(); chk3("s3", 8'h40, 8'h00, 8'h00, 0, 16'd1);
        drive3(2'd0, 8'h00); step(); chk3("s4", 8'h41, 8'h00, 8'h00, 0, 16'd1);
        drive3(2'd0, 8'h00); step(); chk3("s5", 8'h42, 8'h00, 8'h00, 0, 16'd1);
        drive3(2'd0, 8'h00); step(); chk3("s6", 8'h43, 8'h52, 8'h43, 1, 16'd2);
        drive3(2'd1, 8'h60); step(); chk3("s7", 8'h60, 8'h00, 8'h00, 0, 16'd2);
        drive3(2'd1, 8'h70); step(); chk3("s8", 8'h70, 8'h00, 8'h00, 0, 16'd2);
        drive3(2'd0, 8'h00); step(); chk3("s9", 8'h71, 8'h00, 8'h00, 0, 16'd2);
        drive3(2'd0, 8'h00); step(); chk3("s10", 8'h72, 8'h00, 8'h00, 0, 16'd2);
        drive3(2'd0, 8'h00); step(); chk3("s11", 8'h73, 8'h82, 8'h73, 1, 16'd3);
        drive3(2'd1, 8'h60); step(); chk3("s12", 8'h60, 8'h00, 8'h00, 0, 16'd3);
        drive3(2'd0, 8'h00); step(); chk3("s13", 8'h61, 8'h00, 8'h00, 0, 16'd3);

        // async reset mid-operation (dut3 in SQUASH, dut lr=30)
        #1;
        rst_n = 1'b0; rst3_n = 1'b0;
        #1;
        chk3("arst", 8'h00, 8'h00, 8'h00, 0, 16'd0);
        check("arst lr3", 16'(lr3), 16'h00);
        check("arst pc", 16'(pc), 16'h00);
        check("arst lr", 16'(lr), 16'h00);
        check("arst cnt", fetch_cnt, 16'd0);
        check("arst valid", 16'(id_valid), 16'h0);
        @(negedge clk);
        rst_n = 1'b1; rst3_n = 1'b1;
        step();
        chk3("boot", 8'h00, 8'h00, 8'h00, 0, 16'd0);
        check("boot pc", 16'(pc), 16'h00);
        check("boot valid", 16'(id_valid), 16'h0);
        step();
        chk3("post", 8'h01, 8'h10, 8'h01, 1, 16'd1);
        check("post pc", 16'(pc), 16'h01);
        check("post ins", 16'(id_ins), 16'h10);
        check("post cnt", fetch_cnt, 16'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
